// File: rtl/wishbone_uart_initiator.sv
// Wishbone slave that sends each bus cycle as a 4-byte UART command and waits for a 1-byte reply.
// Optional response timeout: define WB_UART_INITIATOR_TIMEOUT_EN.
module wishbone_uart_initiator #(
    parameter int unsigned CLKS_PER_BIT   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [22:0] adr_i,
    input  logic [7:0]  dat_i,
    output logic        ack_o,
    output logic        err_o,
    output logic [7:0]  dat_o,
    output logic        uart_txd,
    input  logic        uart_rxd
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BitLast  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HalfLast = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        StIdle, StTxStart, StTxData, StTxStop, StRxWait, StRxStart, StRxData, StRxStop
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic          we_q, we_d;
    logic [22:0]   adr_q, adr_d;
    logic [7:0]    wdat_q, wdat_d;
    logic          txd_q, txd_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic [7:0]    dat_q, dat_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic          abort_q, abort_d;
    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    logic [7:0]    cur_byte;
    logic [2:0]    bit_nxt;
    logic          tmo_hit;

`ifdef WB_UART_INITIATOR_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_q, tmo_d;

    // Runs from RX_WAIT entry; false starts keep counting.
    always_comb begin
        tmo_d = '0;
        if (state_q == StRxWait || state_q == StRxStart) tmo_d = tmo_q + TW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) tmo_q <= '0;
        else         tmo_q <= tmo_d;
    end

    assign tmo_hit = (tmo_q == TmoLast);
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        unique case (byte_q)
            2'd0:    cur_byte = {we_q, adr_q[22:16]};
            2'd1:    cur_byte = adr_q[15:8];
            2'd2:    cur_byte = adr_q[7:0];
            default: cur_byte = wdat_q;
        endcase
    end

    assign bit_nxt = bit_q + 3'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        txd_d   = txd_q;
        rx_sh_d = rx_sh_q;
        dat_d   = dat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        // A dropped cycle is remembered so the eventual completion stays silent.
        abort_d = abort_q | ((state_q != StIdle) & ~cyc_i);

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                // Hold off while the previous completion pulse is still visible.
                if (cyc_i && stb_i && !ack_q && !err_q) begin
                    we_d    = we_i;
                    adr_d   = adr_i;
                    wdat_d  = we_i ? dat_i : 8'h00;
                    abort_d = 1'b0;
                    byte_d  = 2'd0;
                    bit_d   = 3'd0;
                    txd_d   = 1'b0;
                    state_d = StTxStart;
                end
            end
            StTxStart: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    txd_d   = cur_byte[0];
                    state_d = StTxData;
                end else cnt_d = cnt_q + CW'(1);
            end
            StTxData: begin
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = StTxStop;
                    end else begin
                        bit_d = bit_nxt;
                        txd_d = cur_byte[bit_nxt];
                    end
                end else cnt_d = cnt_q + CW'(1);
            end
            StTxStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (byte_q == 2'd3) state_d = StRxWait;
                    else begin
                        byte_d  = byte_q + 2'd1;
                        txd_d   = 1'b0;
                        state_d = StTxStart;
                    end
                end else cnt_d = cnt_q + CW'(1);
            end
            StRxWait: begin
                cnt_d = '0;
                if (tmo_hit) begin
                    err_d   = ~abort_d;
                    state_d = StIdle;
                end else if (rx_prev_q && !rx_s2_q) state_d = StRxStart;
            end
            StRxStart: begin
                if (tmo_hit) begin
                    err_d   = ~abort_d;
                    state_d = StIdle;
                end else if (cnt_q == HalfLast) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = rx_s2_q ? StRxWait : StRxData;
                end else cnt_d = cnt_q + CW'(1);
            end
            StRxData: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
                    if (bit_q == 3'd7) state_d = StRxStop;
                    else               bit_d   = bit_nxt;
                end else cnt_d = cnt_q + CW'(1);
            end
            StRxStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (rx_s2_q) begin
                        ack_d = ~abort_d;
                        if (!abort_d) dat_d = rx_sh_q;
                    end else err_d = ~abort_d;
                end else cnt_d = cnt_q + CW'(1);
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            byte_q    <= 2'd0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            wdat_q    <= 8'h00;
            txd_q     <= 1'b1;
            rx_sh_q   <= 8'h00;
            dat_q     <= 8'h00;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            abort_q   <= 1'b0;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            txd_q     <= txd_d;
            rx_sh_q   <= rx_sh_d;
            dat_q     <= dat_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            abort_q   <= abort_d;
            rx_s1_q   <= uart_rxd;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    assign ack_o    = ack_q & cyc_i & stb_i;
    assign err_o    = err_q & cyc_i & stb_i;
    assign dat_o    = dat_q;
    assign uart_txd = txd_q;

endmodule

// File: tb/tb_wishbone_uart_initiator.sv
// Directed bench for wishbone_uart_initiator: frame decode, responder model, error and abort paths.
module tb_wishbone_uart_initiator;

`ifdef WB_UART_INITIATOR_TIMEOUT_EN
    localparam int unsigned TmoCycles = 100;
`else
    localparam int unsigned TmoCycles = 4096;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [22:0] adr = '0;
    logic [7:0]  din = 8'h00;
    logic        ack;
    logic        err;
    logic [7:0]  dout;
    logic        txd;
    logic        rxd = 1'b1;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc_n    = 0;
    int ack_cnt  = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int ev_cyc   = 0;

    wishbone_uart_initiator #(
        .CLKS_PER_BIT  (16),
        .TIMEOUT_CYCLES(TmoCycles)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .cyc_i   (cyc),
        .stb_i   (stb),
        .we_i    (we),
        .adr_i   (adr),
        .dat_i   (din),
        .ack_o   (ack),
        .err_o   (err),
        .dat_o   (dout),
        .uart_txd(txd),
        .uart_rxd(rxd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (ack) begin
            ack_cnt <= ack_cnt + 1;
            ev_cyc  <= cyc_n;
        end
        if (err) begin
            err_cnt <= err_cnt + 1;
            ev_cyc  <= cyc_n;
        end
        if (ack && err) both_cnt <= both_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue a bus cycle and check every cycle of the 640-cycle command frame.
    task automatic send_frame(input logic w, input logic [22:0] a, input logic [7:0] d,
                              input logic [31:0] exp, input int drop_c, output int wait_cyc);
        logic [39:0] bits;
        logic [7:0]  eb;
        logic [7:0]  got [4];
        int          bad;
        int          b;
        bad = 0;
        for (int j = 0; j < 4; j++) begin
            eb = exp[31-8*j -: 8];
            got[j] = 8'h00;
            bits[j*10] = 1'b0;
            for (int i = 0; i < 8; i++) bits[j*10+1+i] = eb[i];
            bits[j*10+9] = 1'b1;
        end
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; din = d;
        @(posedge clk);
        for (int c = 0; c < 640; c++) begin
            @(negedge clk);
            b = c / 16;
            if (txd !== bits[b]) bad++;
            if (c % 16 == 8 && b % 10 >= 1 && b % 10 <= 8) got[b/10][b%10-1] = txd;
            if (c == drop_c) begin
                cyc = 1'b0; stb = 1'b0;
            end
            @(posedge clk);
        end
        #1;
        wait_cyc = cyc_n;
        check_eq("frame_bits", bad, 0);
        for (int j = 0; j < 4; j++) begin
            eb = exp[31-8*j -: 8];
            check_eq($sformatf("byte%0d", j), {24'h0, got[j]}, {24'h0, eb});
        end
    endtask

    // Responder model; in parallel, release the bus once a completion pulse is seen.
    task automatic respond(input logic [7:0] bv, input logic stop_bit, input logic glitch,
                           output int rel);
        logic [9:0] bits;
        int         r;
        bits = {stop_bit, bv, 1'b0};
        r = 0;
        fork
            begin
                if (glitch) begin
                    rxd = 1'b0;
                    repeat (3) @(posedge clk);
                    #1 rxd = 1'b1;
                    repeat (30) @(posedge clk);
                    #1;
                end
                r = cyc_n;
                for (int i = 0; i < 10; i++) begin
                    rxd = bits[i];
                    repeat (16) @(posedge clk);
                    #1;
                end
                rxd = 1'b1;
            end
            begin
                for (int i = 0; i < 250; i++) begin
                    @(negedge clk);
                    if (ack || err) break;
                end
                @(posedge clk); #1;
                cyc = 1'b0; stb = 1'b0;
            end
        join
        rel = ev_cyc - r;
    endtask

    initial begin
        int w;
        int rel;
        int a0;
        int e0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_txd", {31'b0, txd}, 1);
        check_eq("rst_ack", {31'b0, ack}, 0);
        check_eq("rst_err", {31'b0, err}, 0);
        check_eq("rst_dat", {24'h0, dout}, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Write, responder answers 0x00
        a0 = ack_cnt; e0 = err_cnt;
        send_frame(1'b1, 23'h012345, 8'hA5, 32'h812345A5, -1, w);
        respond(8'h00, 1'b1, 1'b0, rel);
        check_eq("wr_ack", ack_cnt - a0, 1);
        check_eq("wr_err", err_cnt - e0, 0);
        check_eq("wr_ack_time", rel, 155);
        check_eq("wr_dat", {24'h0, dout}, 32'h00);

        // Read, data forced to 0 in the frame
        a0 = ack_cnt; e0 = err_cnt;
        send_frame(1'b0, 23'h7FFFFF, 8'hFF, 32'h7FFFFF00, -1, w);
        respond(8'h3C, 1'b1, 1'b0, rel);
        check_eq("rd_ack", ack_cnt - a0, 1);
        check_eq("rd_err", err_cnt - e0, 0);
        check_eq("rd_dat", {24'h0, dout}, 32'h3C);

        // Framing error on the response
        a0 = ack_cnt; e0 = err_cnt;
        send_frame(1'b1, 23'h000010, 8'h5E, 32'h8000105E, -1, w);
        respond(8'h99, 1'b0, 1'b0, rel);
        check_eq("fe_err", err_cnt - e0, 1);
        check_eq("fe_ack", ack_cnt - a0, 0);
        check_eq("fe_err_time", rel, 155);
        check_eq("fe_dat_kept", {24'h0, dout}, 32'h3C);

        a0 = ack_cnt;
        send_frame(1'b0, 23'h000001, 8'h00, 32'h00000100, -1, w);
        respond(8'hC3, 1'b1, 1'b0, rel);
        check_eq("fe_next_ack", ack_cnt - a0, 1);
        check_eq("fe_next_dat", {24'h0, dout}, 32'hC3);

        // Short glitch in RX_WAIT before a valid response
        a0 = ack_cnt; e0 = err_cnt;
        send_frame(1'b0, 23'h400000, 8'h00, 32'h40000000, -1, w);
        respond(8'h5A, 1'b1, 1'b1, rel);
        check_eq("gl_ack", ack_cnt - a0, 1);
        check_eq("gl_err", err_cnt - e0, 0);
        check_eq("gl_dat", {24'h0, dout}, 32'h5A);

        // cyc dropped during byte 1
        a0 = ack_cnt; e0 = err_cnt;
        send_frame(1'b0, 23'h00ABCD, 8'h00, 32'h00ABCD00, 200, w);
        respond(8'h77, 1'b1, 1'b0, rel);
        check_eq("ab_ack", ack_cnt - a0, 0);
        check_eq("ab_err", err_cnt - e0, 0);

        a0 = ack_cnt;
        send_frame(1'b0, 23'h000002, 8'h00, 32'h00000200, -1, w);
        respond(8'h11, 1'b1, 1'b0, rel);
        check_eq("ab_next_ack", ack_cnt - a0, 1);
        check_eq("ab_next_dat", {24'h0, dout}, 32'h11);

        // Silent responder
        a0 = ack_cnt; e0 = err_cnt;
        send_frame(1'b0, 23'h000003, 8'h00, 32'h00000300, -1, w);
`ifdef WB_UART_INITIATOR_TIMEOUT_EN
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (err) break;
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        check_eq("to_err", err_cnt - e0, 1);
        check_eq("to_ack", ack_cnt - a0, 0);
        check_eq("to_time", ev_cyc - w, 100);
        a0 = ack_cnt;
        send_frame(1'b0, 23'h000004, 8'h00, 32'h00000400, -1, w);
        respond(8'h22, 1'b1, 1'b0, rel);
        check_eq("to_next_ack", ack_cnt - a0, 1);
        check_eq("to_next_dat", {24'h0, dout}, 32'h22);
`else
        repeat (10000) @(posedge clk);
        #1;
        check_eq("nt_err", err_cnt - e0, 0);
        check_eq("nt_ack", ack_cnt - a0, 0);
        respond(8'h22, 1'b1, 1'b0, rel);
        check_eq("nt_late_ack", ack_cnt - a0, 1);
        check_eq("nt_late_dat", {24'h0, dout}, 32'h22);
`endif

        check_eq("ack_err_overlap", both_cnt, 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
